// File: rtl/print_port_resp.sv
// Print-port AXI write responder: accepts single-lane character writes to a
// fixed address, queues the bytes in a small FIFO, and answers every write
// with an AXI B response.
module print_port_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h90000000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         awvalid,
  output logic         awready,
  input  logic [39:0]  awaddr,
  input  logic [3:0]   awlen,
  input  logic [7:0]   awid,
  input  logic         wvalid,
  output logic         wready,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         wlast,
  output logic         bvalid,
  input  logic         bready,
  output logic [1:0]   bresp,
  output logic [7:0]   bid,
  output logic         char_vld,
  output logic [7:0]   char_data,
  input  logic         char_rdy,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t      state, next_state;
  logic        match_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic [7:0]  id_q;
  logic        err_q;
  logic [1:0]  bresp_q;
  logic [15:0] drop_q;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;

  logic        awready_i, wready_i, bvalid_i;
  logic        aw_hs, w_hs, pop, push, drop;
  logic        empty, full;
  logic        strb_char, char_beat, last_beat, wlast_bad;
  logic [7:0]  lane_byte;
  logic [1:0]  resp_next;

  // Address bits outside the decoded window and the non-lane data bytes are
  // intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{awaddr[39:32], awaddr[3:0], wdata[127:104],
                         wdata[95:72], wdata[63:40], wdata[31:8]};

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // Strobe decode: only a full 32-bit lane write carries a character, taken
  // from the lowest byte of that lane.
  always_comb begin
    strb_char = 1'b1;
    lane_byte = '0;
    case (wstrb)
      16'h000f: lane_byte = wdata[7:0];
      16'h00f0: lane_byte = wdata[39:32];
      16'h0f00: lane_byte = wdata[71:64];
      16'hf000: lane_byte = wdata[103:96];
      default:  strb_char = 1'b0;
    endcase
  end

  assign char_beat = (len_q == 4'd0) && match_q && strb_char;
  assign last_beat = (beat_q == len_q);
  assign wlast_bad = (wlast != last_beat);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign pop   = char_vld && char_rdy;
  // A char beat is single-beat, so a correct wlast is simply wlast=1.
  assign push  = w_hs && char_beat && wlast;
  assign drop  = w_hs && match_q && (len_q == 4'd0) && !strb_char;

  // DECERR wins over SLVERR; SLVERR covers bursts and any wlast misplacement.
  always_comb begin
    resp_next = 2'b00;
    if (!match_q)                                    resp_next = 2'b11;
    else if ((len_q != 4'd0) || err_q || wlast_bad)  resp_next = 2'b10;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    awready_i  = 1'b0;
    wready_i   = 1'b0;
    bvalid_i   = 1'b0;
    case (state)
      IDLE: begin
        awready_i = 1'b1;
        if (awvalid) next_state = DATA;
      end
      DATA: begin
        wready_i = !(char_beat && full);
        if (wvalid && wready_i && last_beat) next_state = RESP;
      end
      RESP: begin
        bvalid_i = 1'b1;
        if (bready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are forced to their reset values whenever reset is asserted.
  assign awready   = awready_i && pad_cpu_rst_b;
  assign wready    = wready_i && pad_cpu_rst_b;
  assign bvalid    = bvalid_i && pad_cpu_rst_b;
  assign bresp     = pad_cpu_rst_b ? bresp_q : '0;
  assign bid       = pad_cpu_rst_b ? id_q : '0;
  assign drop_cnt  = pad_cpu_rst_b ? drop_q : '0;
  assign char_vld  = pad_cpu_rst_b && !empty;
  assign char_data = char_vld ? mem[rptr[AW-1:0]] : '0;

  // State register.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) state <= IDLE;
    else                state <= next_state;
  end

  // Per-transaction context: latched AW fields, beat count and error status.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      match_q <= 1'b0;
      len_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      bresp_q <= '0;
    end else begin
      if (aw_hs) begin
        match_q <= (awaddr[31:4] == BASE_ADDR[31:4]);
        len_q   <= awlen;
        id_q    <= awid;
        beat_q  <= '0;
        err_q   <= 1'b0;
      end
      if (w_hs) begin
        beat_q <= beat_q + 4'd1;
        err_q  <= err_q || wlast_bad;
        if (last_beat) bresp_q <= resp_next;
      end
    end
  end

  // Saturating count of matching single-beat writes that carried no character.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b)                drop_q <= '0;
    else if (drop && (drop_q != '1))   drop_q <= drop_q + 16'd1;
  end

  // FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge pll_core_cpuclk) begin
    if (push) mem[wptr[AW-1:0]] <= lane_byte;
  end

endmodule

// File: tb/tb_print_port_resp.sv
// Randomized self-checking bench for print_port_resp with a transaction-level
// reference model (expected byte queue, drop counter, response code).
module tb_print_port_resp;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         awvalid, awready;
  logic [39:0]  awaddr;
  logic [3:0]   awlen;
  logic [7:0]   awid;
  logic         wvalid, wready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [7:0]   bid;
  logic         char_vld;
  logic [7:0]   char_data;
  logic         char_rdy;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  print_port_resp #(.BASE_ADDR(32'h90000000), .FIFO_DEPTH(8)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .char_vld(char_vld), .char_data(char_data), .char_rdy(char_rdy),
    .drop_cnt(drop_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  int exp_drop = 0;
  int rdy_mode = 0;   // 0 = hold char_rdy low, 1 = high, 2 = random

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Consumer ready driver.
  initial begin
    char_rdy = 1'b0;
    forever begin
      @(negedge clk);
      char_rdy = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
    end
  end

  // Pop monitor: every byte the consumer takes must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_b && char_vld && char_rdy) begin
        if (exp_q.size() == 0) chk("pop_underflow", 40'(char_data), 40'hx_dead);
        else                   chk("char_data", 40'(char_data), 40'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic is_char_strb(input logic [15:0] s);
    return (s == 16'h000f) || (s == 16'h00f0) || (s == 16'h0f00) || (s == 16'hf000);
  endfunction

  function automatic logic [7:0] lane_of(input logic [15:0] s, input logic [127:0] d);
    int unsigned idx;
    idx = (s == 16'h000f) ? 0 : (s == 16'h00f0) ? 4 : (s == 16'h0f00) ? 8 : 12;
    return d[8*idx +: 8];
  endfunction

  task automatic do_aw(input logic [39:0] a, input logic [3:0] l, input logic [7:0] id);
    int n = 0;
    awvalid = 1'b1; awaddr = a; awlen = l; awid = id;
    #1;
    while (!awready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) chk("aw_timeout", 40'(awready), 40'(1));
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_beat(input logic [127:0] d, input logic [15:0] s, input logic last,
                         input logic exp_push);
    int n = 0;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
    #1;
    while (!wready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) chk("w_timeout", 40'(wready), 40'(1));
    if (exp_push) exp_q.push_back(lane_of(s, d));
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Called on the cycle after the last W handshake; bvalid must already be up.
  task automatic do_b(input logic [1:0] er, input logic [7:0] id, input int hold);
    bready = 1'b0;
    #1;
    chk("bvalid_lat", 40'(bvalid), 40'(1));
    chk("bresp", 40'(bresp), 40'(er));
    chk("bid", 40'(bid), 40'(id));
    for (int h = 0; h < hold; h++) begin
      awvalid = 1'b1; awaddr = 40'h90000000; awlen = 4'd0; awid = 8'hee;
      @(negedge clk); #1;
      chk("hold_bvalid", 40'(bvalid), 40'(1));
      chk("hold_bresp", 40'(bresp), 40'(er));
      chk("hold_bid", 40'(bid), 40'(id));
      chk("hold_aw_blocked", 40'(awready), 40'(0));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0;
    #1;
    chk("idle_awready", 40'(awready), 40'(1));
  endtask

  // Complete write transaction, predicted from the print-port rules.
  task automatic wr_txn(input logic [39:0] a, input logic [3:0] l, input logic [7:0] id,
                        input logic [15:0] s, input logic [127:0] d, input logic bad_wlast,
                        input int hold);
    logic       match, chr, last;
    logic [1:0] er;
    match = (a[31:4] == 28'h9000000);
    chr   = is_char_strb(s);
    er    = !match ? 2'b11 : ((l != 0) || bad_wlast) ? 2'b10 : 2'b00;
    do_aw(a, l, id);
    for (int b = 0; b <= int'(l); b++) begin
      last = (b == int'(l)) ^ (bad_wlast && b == 0);
      do_beat(d, s, last, match && l == 0 && chr && last);
    end
    if (match && l == 0 && !chr && exp_drop < 65535) exp_drop++;
    do_b(er, id, hold);
    chk("drop_cnt", 40'(drop_cnt), 40'(exp_drop));
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 1;
    @(negedge clk);
    while (char_vld && n < 100) begin @(negedge clk); n++; end
    #3;
    chk("drained_vld", 40'(char_vld), 40'(0));
    chk("drained_model", 40'(exp_q.size()), 40'(0));
    rdy_mode = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] s;
    logic [3:0]  l;
    logic [39:0] a;
    logic [127:0] d;
    rst_b = 1'b0; awvalid = 1'b0; awaddr = '0; awlen = '0; awid = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", 40'(awready), 40'(0));
    chk("rst_wready", 40'(wready), 40'(0));
    chk("rst_bvalid", 40'(bvalid), 40'(0));
    chk("rst_char_vld", 40'(char_vld), 40'(0));
    chk("rst_drop", 40'(drop_cnt), 40'(0));
    chk("rst_bresp_bid", 40'({bresp, bid}), 40'(0));
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rel_awready", 40'(awready), 40'(1));

    // Basic character write, lane 1
    do_aw(40'h90000000, 4'd0, 8'd5);
    #1;
    chk("wready_lat", 40'(wready), 40'(1));
    d = 128'h41 << 32;
    do_beat(d, 16'h00f0, 1'b1, 1'b1);
    #1;
    chk("char_vld_lat", 40'(char_vld), 40'(1));
    chk("char_first", 40'(char_data), 40'(8'h41));
    do_b(2'b00, 8'd5, 0);
    drain();

    // FIFO full backpressure: eight fill, ninth stalls until a pop
    for (int i = 0; i < 8; i++) begin
      s = 16'h000f << (4 * (i % 4));
      d = {16{8'h61 + 8'(i)}};
      wr_txn(40'h90000000, 4'd0, 8'(i), s, d, 1'b0, 0);
    end
    do_aw(40'h90000004, 4'd0, 8'h09);
    wvalid = 1'b1; wdata = {16{8'h69}}; wstrb = 16'hf000; wlast = 1'b1;
    #1;
    chk("full_wready", 40'(wready), 40'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("full_wready_hold", 40'(wready), 40'(0));
      chk("full_no_bvalid", 40'(bvalid), 40'(0));
    end
    rdy_mode = 1;
    do_beat({16{8'h69}}, 16'hf000, 1'b1, 1'b1);
    do_b(2'b00, 8'h09, 0);
    drain();

    // Burst SLVERR, address DECERR
    wr_txn(40'h90000000, 4'd3, 8'h21, 16'h000f, {16{8'h55}}, 1'b0, 0);
    #1; chk("burst_no_push", 40'(char_vld), 40'(0));
    wr_txn(40'h80000000, 4'd0, 8'h22, 16'h000f, {16{8'h56}}, 1'b0, 0);
    #1; chk("decerr_no_push", 40'(char_vld), 40'(0));

    // Dropped strobe pattern, then wlast error on a char beat
    wr_txn(40'h90000008, 4'd0, 8'h31, 16'h0003, {16{8'h57}}, 1'b0, 0);
    wr_txn(40'h90000000, 4'd0, 8'h32, 16'h000f, {16{8'h58}}, 1'b1, 0);
    #1; chk("wlast_err_no_push", 40'(char_vld), 40'(0));

    // Response held by bready=0 with a competing AW
    wr_txn(40'h90000000, 4'd0, 8'h77, 16'h0f00, {16{8'h59}}, 1'b0, 5);
    drain();

    // Reset in RESP with two bytes queued
    wr_txn(40'h90000000, 4'd0, 8'h41, 16'h000f, {16{8'h31}}, 1'b0, 0);
    wr_txn(40'h90000000, 4'd0, 8'h42, 16'h000f, {16{8'h32}}, 1'b0, 0);
    do_aw(40'h80000000, 4'd0, 8'h43);
    do_beat('0, 16'h000f, 1'b1, 1'b0);
    #1;
    chk("pre_rst_bvalid", 40'(bvalid), 40'(1));
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_bvalid", 40'(bvalid), 40'(0));
    chk("mid_rst_char_vld", 40'(char_vld), 40'(0));
    chk("mid_rst_drop", 40'(drop_cnt), 40'(0));
    chk("mid_rst_awready", 40'(awready), 40'(0));
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("post_rst_awready", 40'(awready), 40'(1));
    chk("post_rst_char_vld", 40'(char_vld), 40'(0));
    @(negedge clk);

    // Randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      case ($urandom % 6)
        0: s = 16'h000f;
        1: s = 16'h00f0;
        2: s = 16'h0f00;
        3: s = 16'hf000;
        4: s = 16'h0003;
        default: s = 16'($urandom);
      endcase
      l = ($urandom % 4 == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      if ($urandom % 8 == 0) a = {8'($urandom), 32'h70000000 | 32'($urandom % 16)};
      else                   a = {8'($urandom), 28'h9000000, 4'($urandom)};
      d = {$urandom, $urandom, $urandom, $urandom};
      wr_txn(a, l, 8'($urandom), s, d, 1'($urandom % 8 == 0), int'($urandom % 3));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/print_port_resp.md
PRINT_PORT_RESP -- requirements
Module: print_port_resp

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h90000000, meaning the print-port address; match is on awaddr[31:4] only.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8 (power of 2), meaning the number of character FIFO entries.
REQ-003 The block SHALL have one clock and one reset: clock pll_core_cpuclk; reset pad_cpu_rst_b, synchronous and active-low.
REQ-004 The block SHALL have the following ports:
  pll_core_cpuclk  in  1  clock
  pad_cpu_rst_b  in  1  synchronous active-low reset
  awvalid  in  1  write-address valid
  awready  out  1  write-address ready
  awaddr  in  40  write address
  awlen  in  4  burst length minus 1
  awid  in  8  transaction ID
  wvalid  in  1  write-data valid
  wready  out  1  write-data ready
  wdata  in  128  write data
  wstrb  in  16  byte strobes
  wlast  in  1  last beat
  bvalid  out  1  response valid
  bready  in  1  response ready
  bresp  out  2  response code
  bid  out  8  echoed awid
  char_vld  out  1  character available
  char_data  out  8  character byte
  char_rdy  in  1  consumer accepts character
  drop_cnt  out  16  saturating count of dropped writes

Function
REQ-005 The FSM SHALL have three states, IDLE, DATA and RESP, and SHALL reset to IDLE.
REQ-006 In IDLE, awready SHALL be 1; wready and bvalid SHALL be 0.
REQ-007 When awvalid&awready is high, the block SHALL latch awaddr, awlen and awid, clear its beat counter, and move to DATA.
REQ-008 In DATA, wready SHALL be 1 except when the current beat is a char beat (REQ-009) and the FIFO is full.
REQ-009 A beat SHALL be a char beat when all of the following hold:
  - awlen==0
  - awaddr[31:4]==BASE_ADDR[31:4]
  - wstrb is one of 16'h000f, 16'h00f0, 16'h0f00 or 16'hf000
REQ-010 For an accepted char beat, the block SHALL push the low byte of the strobed lane: wdata[7:0], [39:32], [71:64] or [103:96] respectively.
REQ-011 For a single-beat write that matches the address but has any other wstrb, the block SHALL push nothing, SHALL increment drop_cnt (saturating at 16'hffff), and SHALL return bresp 2'b00.
REQ-012 For an address mismatch, all beats SHALL be consumed, nothing SHALL be pushed, and bresp SHALL be 2'b11 (DECERR).
REQ-013 For a matching address with awlen!=0, all awlen+1 beats SHALL be consumed, nothing SHALL be pushed, and bresp SHALL be 2'b10 (SLVERR).
REQ-014 DATA SHALL exit to RESP on the beat where the beat count equals awlen, regardless of wlast.
REQ-015 If any beat's wlast disagrees with (beat==awlen), bresp SHALL be 2'b10; this SLVERR SHALL override the OKAY result but not DECERR.
REQ-016 A char beat pushes, and bresp is 2'b00, when REQ-012, REQ-013 and REQ-015 do not apply.
REQ-017 In RESP, bvalid SHALL be 1 and bid SHALL equal the latched awid; bvalid, bresp and bid SHALL remain stable until bready.
REQ-018 On bvalid&bready, the FSM SHALL return to IDLE, so a new AW can be accepted no earlier than the following cycle.
REQ-019 Latency: AW handshake in cycle N gives wready at N+1 at the earliest; the last W handshake in cycle M gives bvalid at M+1.
REQ-020 If the FIFO was empty, a push in cycle M SHALL give char_vld=1 with the pushed byte at M+1; there is no write-to-read bypass.
REQ-021 char_vld SHALL equal FIFO-not-empty; char_data SHALL be the FIFO head; a pop occurs on char_vld&char_rdy.
REQ-022 A simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged and preserve byte order.
REQ-023 When the FIFO is full, wready SHALL be 0 for a char beat even if a pop occurs in the same cycle; the beat SHALL be accepted the next cycle.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB to distinguish full from empty.
REQ-025 awvalid while in DATA or RESP SHALL be ignored, since awready=0; the address SHALL be held by the initiator.

Reset
REQ-026 While pad_cpu_rst_b is sampled 0, the following SHALL hold, including when reset is asserted mid-transaction (any in-flight response is discarded):
  - FSM in IDLE and FIFO empty
  - drop_cnt=0
  - awready=0, wready=0, bvalid=0, bresp=0, bid=0
  - char_vld=0, char_data=0
REQ-027 awready SHALL rise in the first cycle after reset is released.

Verification
REQ-028 AW 0x90000000 len 0 id 5, W wstrb 16'h00f0 wdata[39:32]=0x41, bready=1 -> char_data 0x41 with char_vld one cycle after the W handshake; bvalid with bresp 0, bid 5.
REQ-029 char_rdy=0, nine char writes 'a'..'i' with FIFO_DEPTH=8 -> wready low on the ninth beat and bvalid withheld; raise char_rdy -> 'a'..'i' popped in order and ninth bresp 0.
REQ-030 AW 0x90000000 len 3, four beats with wlast on beat 3 -> no push, bresp 2'b10; then AW 0x80000000 len 0 -> bresp 2'b11, no push.
REQ-031 Single write with wstrb 16'h0003 -> no push, drop_cnt 1, bresp 0; len-0 write with wlast=0 -> bresp 2'b10.
REQ-032 Pulse reset while in RESP with two bytes queued -> bvalid 0, char_vld 0, drop_cnt 0, awready 1 the cycle after release.
REQ-033 Hold bready=0 for 5 cycles in RESP -> bvalid, bresp and bid stable; a concurrent awvalid is not accepted until after the B handshake.
